// File: rtl/lbist_pkg.sv
// Shared types and defaults for the logic-BIST controller.
package lbist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SHIFT,
    ST_CAPTURE,
    ST_UNLOAD,
    ST_COMPARE,
    ST_DONE
  } lbist_state_e;

  localparam logic [31:0] LBIST_LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LBIST_LFSR_SEED = 32'h0000_0001;
  localparam logic [31:0] LBIST_MISR_POLY = 32'h04C1_1DB7;

  // Busy cycles from INIT to COMPARE inclusive.
  function automatic int unsigned lbist_run_cycles(input int unsigned n_patterns,
                                                   input int unsigned chain_len);
    return 2 + n_patterns * (chain_len + 1) + chain_len;
  endfunction

endpackage

// File: rtl/lbist_misr.sv
// Multiple-input signature register with synchronous clear and update enable.
module lbist_misr #(
  parameter int unsigned            WIDTH    = 32,
  parameter int unsigned            IN_WIDTH = 4,
  parameter logic [WIDTH-1:0]       POLY     = 32'h04C1_1DB7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                en,
  input  logic [IN_WIDTH-1:0] data,
  output logic [WIDTH-1:0]    sig
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clear) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ WIDTH'(data);
    end
  end

endmodule

// File: rtl/lbist_ctrl.sv
// Multi-chain LBIST engine: LFSR pattern source, shift/capture sequencing, MISR compaction.
// Build option LBIST_PHASE_SHIFTER_EN: XOR a second LFSR tap into each chain's stimulus.
module lbist_ctrl
  import lbist_pkg::*;
#(
  parameter int unsigned              N_CHAINS   = 4,
  parameter int unsigned              CHAIN_LEN  = 64,
  parameter int unsigned              N_PATTERNS = 256,
  parameter int unsigned              LFSR_WIDTH = 32,
  parameter logic [LFSR_WIDTH-1:0]    LFSR_POLY  = LFSR_WIDTH'(LBIST_LFSR_POLY),
  parameter logic [LFSR_WIDTH-1:0]    LFSR_SEED  = LFSR_WIDTH'(LBIST_LFSR_SEED),
  parameter int unsigned              MISR_WIDTH = 32,
  parameter logic [MISR_WIDTH-1:0]    MISR_POLY  = MISR_WIDTH'(LBIST_MISR_POLY),
  parameter logic [MISR_WIDTH-1:0]    GOLDEN_SIG = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  test_mode_i,
  output logic                  scan_en_o,
  output logic [N_CHAINS-1:0]   scan_in_o,
  input  logic [N_CHAINS-1:0]   scan_out_i,
  output logic                  busy_o,
  output logic                  test_over_o,
  output logic                  go_nogo_o,
  output logic [MISR_WIDTH-1:0] signature_o
);

  localparam int unsigned SHIFT_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned PAT_W   = $clog2(N_PATTERNS + 1);
  localparam int unsigned IDX_W   = $clog2(LFSR_WIDTH);

  lbist_state_e          state, state_nxt;
  logic [LFSR_WIDTH-1:0] lfsr, lfsr_nxt;
  logic [SHIFT_W-1:0]    shift_cnt;
  logic [PAT_W-1:0]      pat_cnt;
  logic [N_CHAINS-1:0]   stim;
  logic                  last_shift;
  logic                  last_pat;
  logic                  misr_en;
  logic                  misr_clear;

  assign last_shift = (shift_cnt == SHIFT_W'(CHAIN_LEN - 1));
  assign last_pat   = (32'(pat_cnt) + 32'd1 >= N_PATTERNS);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (test_mode_i) state_nxt = ST_INIT;
      ST_INIT:    state_nxt = ST_SHIFT;
      ST_SHIFT:   if (last_shift) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = last_pat ? ST_UNLOAD : ST_SHIFT;
      ST_UNLOAD:  if (last_shift) state_nxt = ST_COMPARE;
      ST_COMPARE: state_nxt = ST_DONE;
      ST_DONE:    if (!test_mode_i) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
    if (!test_mode_i && state != ST_DONE) state_nxt = ST_IDLE;
  end

  // An abort freezes the LFSR so a dropped run leaves its state untouched.
  always_comb begin
    lfsr_nxt = lfsr;
    if (test_mode_i && state == ST_INIT) begin
      lfsr_nxt = LFSR_SEED;
    end else if (test_mode_i && state == ST_SHIFT) begin
      lfsr_nxt = {lfsr[LFSR_WIDTH-2:0], ^(lfsr & LFSR_POLY)};
    end
  end

  // Stimulus is formed from the LFSR value the next SHIFT cycle will hold,
  // so the registered scan_in_o lines up with the LFSR state of that cycle.
  always_comb begin
    stim = '0;
    for (int unsigned i = 0; i < N_CHAINS; i++) begin
`ifdef LBIST_PHASE_SHIFTER_EN
      stim[i] = lfsr_nxt[IDX_W'(i % LFSR_WIDTH)] ^
                lfsr_nxt[IDX_W'((i + LFSR_WIDTH / 2) % LFSR_WIDTH)];
`else
      stim[i] = lfsr_nxt[IDX_W'(i % LFSR_WIDTH)];
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      lfsr        <= LFSR_SEED;
      shift_cnt   <= '0;
      pat_cnt     <= '0;
      scan_en_o   <= 1'b0;
      scan_in_o   <= '0;
      busy_o      <= 1'b0;
      test_over_o <= 1'b0;
      go_nogo_o   <= 1'b0;
    end else begin
      state       <= state_nxt;
      lfsr        <= lfsr_nxt;
      scan_en_o   <= (state_nxt == ST_SHIFT) || (state_nxt == ST_UNLOAD);
      scan_in_o   <= (state_nxt == ST_SHIFT) ? stim : '0;
      busy_o      <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
      test_over_o <= (state_nxt == ST_DONE);

      if (state == ST_COMPARE && state_nxt == ST_DONE) begin
        go_nogo_o <= (signature_o == GOLDEN_SIG);
      end else if (state_nxt != ST_DONE) begin
        go_nogo_o <= 1'b0;
      end

      case (state)
        ST_INIT: begin
          shift_cnt <= '0;
          pat_cnt   <= '0;
        end
        ST_SHIFT, ST_UNLOAD: begin
          if (test_mode_i) shift_cnt <= last_shift ? '0 : shift_cnt + 1'b1;
        end
        ST_CAPTURE: begin
          if (test_mode_i) pat_cnt <= pat_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Pattern 0 unloads functional-reset content, so it is never compacted.
  assign misr_en    = test_mode_i &&
                      ((state == ST_SHIFT && pat_cnt != '0) || state == ST_UNLOAD);
  assign misr_clear = test_mode_i && (state == ST_INIT);

  lbist_misr #(
    .WIDTH    (MISR_WIDTH),
    .IN_WIDTH (N_CHAINS),
    .POLY     (MISR_POLY)
  ) u_misr (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .clear (misr_clear),
    .en    (misr_en),
    .data  (scan_out_i),
    .sig   (signature_o)
  );

endmodule
